// File: rtl/hash_absorb_pad_if.sv
// Byte-in / rate-block-out bundle for the absorb padder.
// The slave modport is the padder; the master modport is the byte source and block sink.
interface hash_absorb_pad_if;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [7:0]  io_in_data;
  logic        io_in_last;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [7:0]  io_out_0;
  logic [7:0]  io_out_1;
  logic [7:0]  io_out_2;
  logic [7:0]  io_out_3;
  logic        io_out_last;
  logic [1:0]  io_out_const;
  logic [31:0] io_msg_bytes;

  modport slave (
    input  io_in_valid, io_in_data, io_in_last, io_out_ready,
    output io_in_ready, io_out_valid, io_out_0, io_out_1, io_out_2, io_out_3,
           io_out_last, io_out_const, io_msg_bytes
  );

  modport master (
    output io_in_valid, io_in_data, io_in_last, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_0, io_out_1, io_out_2, io_out_3,
           io_out_last, io_out_const, io_msg_bytes
  );
endinterface

// File: rtl/hash_absorb_pad.sv
// Packs a byte stream into 4-byte rate blocks with 10* padding and a domain tag.
// One register lane per byte slot; a two-state FILL/EMIT controller sequences them.

module hash_absorb_pad_slot #(
  parameter int IDX = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_accept,
  input  logic       i_last,
  input  logic [1:0] i_cnt,
  input  logic [7:0] i_data,
  output logic [7:0] o_byte
);
  localparam logic [1:0] SLOT = 2'(IDX);
  localparam logic [1:0] PREV = 2'(IDX + 3);
  localparam bit         HAS_PREV = (IDX > 0);

  logic       w_wr;
  logic       w_pad;
  logic [7:0] r_byte;

  assign w_wr  = i_accept && (i_cnt == SLOT);
  // The 0x01 pad marker lands in the slot right after the final message byte.
  assign w_pad = HAS_PREV && i_accept && i_last && (i_cnt == PREV);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      r_byte <= 8'h00;
    else if (i_clr)  r_byte <= 8'h00;
    else if (w_wr)   r_byte <= i_data;
    else if (w_pad)  r_byte <= 8'h01;
  end

  assign o_byte = r_byte;
endmodule

module hash_absorb_pad #(
  parameter int NUM_LANES = 4
) (
  input  logic               clock,
  input  logic               reset,
  hash_absorb_pad_if.slave   bus
);
  typedef enum logic {FILL = 1'b0, EMIT = 1'b1} state_t;

  localparam logic [1:0] CONST_MID  = 2'd0;
  localparam logic [1:0] CONST_FULL = 2'd1;
  localparam logic [1:0] CONST_PAD  = 2'd2;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_cnt;
  logic        r_last;
  logic [1:0]  r_const;
  logic [31:0] r_msg_bytes;

  logic        w_accept;
  logic        w_hs;
  logic        w_blk_done;
  logic        w_in_ready;
  logic        w_out_valid;
  logic [NUM_LANES-1:0][7:0] w_slot;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_accept    = 1'b0;
    w_hs        = 1'b0;
    w_blk_done  = 1'b0;
    case (r_state)
      FILL: begin
        w_in_ready = 1'b1;
        w_accept   = bus.io_in_valid;
        w_blk_done = w_accept && ((r_cnt == 2'd3) || bus.io_in_last);
        if (w_blk_done) w_state_nxt = EMIT;
      end
      EMIT: begin
        w_out_valid = 1'b1;
        w_hs        = bus.io_out_ready;
        if (w_hs) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt       <= 2'd0;
      r_last      <= 1'b0;
      r_const     <= CONST_MID;
      r_msg_bytes <= 32'd0;
    end else if (w_hs) begin
      r_cnt   <= 2'd0;
      r_last  <= 1'b0;
      r_const <= CONST_MID;
      if (r_last) r_msg_bytes <= 32'd0;
    end else if (w_accept) begin
      r_cnt       <= r_cnt + 2'd1;
      r_msg_bytes <= r_msg_bytes + 32'd1;
      if (w_blk_done) begin
        r_last  <= bus.io_in_last;
        r_const <= !bus.io_in_last    ? CONST_MID  :
                   (r_cnt == 2'd3)    ? CONST_FULL : CONST_PAD;
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_slot
    hash_absorb_pad_slot #(.IDX(g)) u_slot (
      .clock    (clock),
      .reset    (reset),
      .i_clr    (w_hs),
      .i_accept (w_accept),
      .i_last   (bus.io_in_last),
      .i_cnt    (r_cnt),
      .i_data   (bus.io_in_data),
      .o_byte   (w_slot[g])
    );
  end

  assign bus.io_in_ready  = w_in_ready;
  assign bus.io_out_valid = w_out_valid;
  assign bus.io_out_0     = w_slot[0];
  assign bus.io_out_1     = w_slot[1];
  assign bus.io_out_2     = w_slot[2];
  assign bus.io_out_3     = w_slot[3];
  assign bus.io_out_last  = r_last;
  assign bus.io_out_const = r_const;
  assign bus.io_msg_bytes = r_msg_bytes;
endmodule

// File: doc/hash_absorb_pad.md
HASH_ABSORB_PAD -- requirements
Module: hash_absorb_pad

Purpose: upstream of the hash XOR/absorb stage. Packs a byte stream into 4-byte rate blocks, applies 10* padding, tags each block with a domain constant.

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; the ports are named clock and reset (reset = 0 resets).
REQ-002 Ports (name  direction  width  meaning):
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- io_in_valid  in  1  input byte valid
- io_in_ready  out  1  block accepts a byte this cycle
- io_in_data  in  8  message byte
- io_in_last  in  1  byte is the final message byte
- io_out_valid  out  1  rate block valid
- io_out_ready  in  1  downstream accepts the block
- io_out_0..io_out_3  out  8 each  rate block bytes; io_out_0 holds the first byte received
- io_out_last  out  1  block is the final block of the message
- io_out_const  out  2  domain constant: 0 = mid-message, 1 = full final block, 2 = padded final block
- io_msg_bytes  out  32  bytes accepted in the current message

Function
REQ-003 SHALL implement two states: FILL and EMIT.
REQ-004 In FILL, io_in_ready SHALL be 1; in EMIT, io_in_ready SHALL be 0; there is no bypass.
REQ-005 A byte SHALL be accepted on a rising edge with io_in_valid = 1 and io_in_ready = 1. It SHALL be written to byte slot cnt, where cnt is a 2-bit slot counter starting at 0.
REQ-006 On each accepted byte, cnt SHALL increment, and io_msg_bytes SHALL increment, wrapping modulo 2^32.
REQ-007 Accepting slot 3 with io_in_last = 0 -> EMIT with io_out_last = 0 and io_out_const = 0.
REQ-008 Accepting slot 3 with io_in_last = 1 -> EMIT with io_out_last = 1 and io_out_const = 1; no padding.
REQ-009 Accepting slot k < 3 with io_in_last = 1 -> EMIT with io_out_last = 1 and io_out_const = 2.
- Slot k+1 = 0x01; slots above k+1 = 0x00.
REQ-010 Padding SHALL be applied in the same edge that accepts the last byte. io_out_valid SHALL rise in the cycle after that edge (latency 1 cycle from the accepting edge).
REQ-011 In EMIT, io_out_valid = 1. io_out_0..3, io_out_last and io_out_const SHALL be held stable until io_out_ready = 1 is sampled.
REQ-012 On an EMIT edge with io_out_ready = 1:
- state -> FILL
- cnt -> 0
- all four byte slots -> 0x00
REQ-013 If the emitted block had io_out_last = 1, io_msg_bytes SHALL also clear to 0 on that handshake edge; otherwise it is retained.
REQ-014 In FILL, io_out_valid = 0 and io_out_0..3 SHALL show the partially filled slots. Unfilled slots SHALL read 0x00.
REQ-015 io_in_data and io_in_last SHALL be ignored whenever no byte is accepted.
REQ-016 io_out_ready SHALL be ignored in FILL.
REQ-017 Empty messages are out of scope. Every message carries at least one byte; io_in_last marks its final byte.
REQ-018 Back-to-back messages SHALL be supported: the first byte of the next message can be accepted in the cycle after the final block handshake.

Reset
REQ-019 When reset = 0, asynchronously:
- state = FILL, cnt = 0
- io_out_0..3 = 0x00
- io_out_valid = 0, io_out_last = 0, io_out_const = 0
- io_msg_bytes = 0
REQ-020 A reset asserted mid-block or during EMIT SHALL discard the block and all counts. After reset release, io_in_ready = 1 in the first cycle.

Verification
REQ-021 Bench SHALL cover these scenarios:
- Bytes 0x11,0x22,0x33,0x44 with last on 0x44 -> io_out_0..3 = 11,22,33,44; io_out_last = 1; io_out_const = 1; io_msg_bytes = 4.
- Bytes 0xAA,0xBB with last on 0xBB -> io_out_0..3 = AA,BB,01,00; io_out_const = 2; io_out_last = 1.
- 5 bytes 01..05, last on 05:
  - first block = 01,02,03,04 with const 0, last 0;
  - second block = 05,01,00,00 with const 2, last 1.
- Hold io_out_ready = 0 for 3 cycles in EMIT -> outputs stable; io_in_ready = 0; io_in_valid bytes ignored; the block is released on the first ready cycle.
- Reset pulse low after 2 bytes -> all outputs at reset values. A following 4-byte message emits only its own bytes.
- Single byte 0x80 with last -> block 80,01,00,00; const 2; io_msg_bytes reads 1 before the handshake and 0 after it.
